// File: rtl/writeback_slot_scheduler_pkg.sv
// Shared types and default latencies for the writeback slot scheduler and the
// writeback stage that consumes its reservations.
package writeback_slot_scheduler_pkg;

  localparam int NUM_THREADS         = 4;
  localparam int DEFAULT_SX_LATENCY  = 2;
  localparam int DEFAULT_MEM_LATENCY = 3;
  localparam int DEFAULT_MX_LATENCY  = 6;
  localparam int THREAD_IDX_W        = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

  typedef logic [THREAD_IDX_W-1:0] thread_idx_t;

  typedef enum logic [1:0] {
    PIPE_SCYCLE_ARITH = 2'd0,
    PIPE_MEM          = 2'd1,
    PIPE_MCYCLE_ARITH = 2'd2
  } pipeline_sel_t;

endpackage

// File: rtl/writeback_slot_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from a request mask, pointer advances past
// the winner when update_lru is strobed.
module writeback_slot_scheduler_rr_arbiter #(
  parameter int NUM_REQUESTERS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQUESTERS-1:0] req_mask,
  input  logic                      update_lru,
  output logic [NUM_REQUESTERS-1:0] grant_oh
);

  localparam int PTR_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

  logic [PTR_W-1:0]            ptr_q, ptr_d;
  logic [2*NUM_REQUESTERS-1:0] req_dbl;
  logic [2*NUM_REQUESTERS-1:0] gnt_dbl;
  logic [NUM_REQUESTERS-1:0]   req_rot;
  logic [NUM_REQUESTERS-1:0]   gnt_rot;
  logic [PTR_W-1:0]            next_ptr;
  logic                        found;

  // Rotate so the pointer position is bit 0, pick the lowest request, rotate back.
  always_comb begin
    req_dbl  = {req_mask, req_mask} >> ptr_q;
    req_rot  = req_dbl[NUM_REQUESTERS-1:0];
    gnt_rot  = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (!found && req_rot[i]) begin
        found      = 1'b1;
        gnt_rot[i] = 1'b1;
      end
    end
    gnt_dbl  = {gnt_rot, gnt_rot} << ptr_q;
    grant_oh = gnt_dbl[2*NUM_REQUESTERS-1:NUM_REQUESTERS];
  end

  always_comb begin
    next_ptr = ptr_q;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      if (grant_oh[k]) begin
        next_ptr = (k == NUM_REQUESTERS - 1) ? '0 : PTR_W'(k + 1);
      end
    end
    ptr_d = (update_lru && found) ? next_ptr : ptr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/writeback_slot_scheduler.sv
// Reserves the shared writeback port: grants at most one thread per cycle whose
// pipeline's writeback cycle is still free, and tracks future reservations.
module writeback_slot_scheduler
  import writeback_slot_scheduler_pkg::*;
#(
  parameter int SX_LATENCY  = DEFAULT_SX_LATENCY,
  parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY,
  parameter int MX_LATENCY  = DEFAULT_MX_LATENCY
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_THREADS-1:0] ts_req_valid,
  input  pipeline_sel_t          ts_req_pipeline [NUM_THREADS],
  input  logic                   ss_hold,
  input  logic                   wb_rollback_en,
  input  thread_idx_t            wb_rollback_thread_idx,
  output logic [NUM_THREADS-1:0] wss_grant_oh,
  output logic                   wss_grant_valid,
  output pipeline_sel_t          wss_grant_pipeline,
  output logic [MX_LATENCY-1:0]  wss_slot_busy,
  output logic                   perf_wb_conflict
);

  localparam logic [MX_LATENCY-1:0] SLOT_ONE = {{(MX_LATENCY-1){1'b0}}, 1'b1};

  // Bit j of the slot vector stands for the cycle j+1 ahead of now.
  function automatic logic [MX_LATENCY-1:0] slot_mask(pipeline_sel_t p);
    int lat;
    case (p)
      PIPE_SCYCLE_ARITH: lat = SX_LATENCY;
      PIPE_MEM:          lat = MEM_LATENCY;
      default:           lat = MX_LATENCY;
    endcase
    return SLOT_ONE << (lat - 1);
  endfunction

  logic [MX_LATENCY-1:0]  slot_q, slot_d;
  logic                   perf_wb_conflict_q, perf_wb_conflict_d;
  logic [NUM_THREADS-1:0] busy_hit;
  logic [NUM_THREADS-1:0] rb_hit;
  logic [NUM_THREADS-1:0] eligible;
  logic [NUM_THREADS-1:0] grant_oh;
  logic                   grant_valid;
  pipeline_sel_t          grant_pipeline;
  logic [MX_LATENCY-1:0]  grant_mask;

  always_comb begin
    busy_hit = '0;
    rb_hit   = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      busy_hit[t] = |(slot_q & slot_mask(ts_req_pipeline[t]));
      rb_hit[t]   = wb_rollback_en && (wb_rollback_thread_idx == thread_idx_t'(t));
    end
    eligible = ts_req_valid & ~busy_hit & ~rb_hit & {NUM_THREADS{!ss_hold && !reset}};
  end

  writeback_slot_scheduler_rr_arbiter #(
    .NUM_REQUESTERS (NUM_THREADS)
  ) u_rr_arbiter (
    .clk        (clk),
    .reset      (reset),
    .req_mask   (eligible),
    .update_lru (grant_valid),
    .grant_oh   (grant_oh)
  );

  always_comb begin
    grant_valid    = |grant_oh;
    grant_pipeline = PIPE_SCYCLE_ARITH;
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (grant_oh[t]) begin
        grant_pipeline = ts_req_pipeline[t];
      end
    end
    grant_mask = grant_valid ? slot_mask(grant_pipeline) : '0;
  end

  // Pipelines never stall, so the vector shifts every cycle, held or not.
  always_comb begin
    slot_d             = (slot_q | grant_mask) >> 1;
    perf_wb_conflict_d = !grant_valid && !ss_hold && |(ts_req_valid & ~rb_hit & busy_hit);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q             <= '0;
      perf_wb_conflict_q <= 1'b0;
    end else begin
      slot_q             <= slot_d;
      perf_wb_conflict_q <= perf_wb_conflict_d;
    end
  end

  assign wss_grant_oh       = grant_oh;
  assign wss_grant_valid    = grant_valid;
  assign wss_grant_pipeline = grant_pipeline;
  assign wss_slot_busy      = slot_q;
  assign perf_wb_conflict   = perf_wb_conflict_q;

  a_grant_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(wss_grant_oh));
  a_no_double_book: assert property (@(posedge clk) disable iff (reset)
    !(grant_valid && |(slot_q & grant_mask)));

endmodule

// File: tb/tb_writeback_slot_scheduler.sv
// Scoreboard bench for writeback_slot_scheduler: expected grants are queued as
// stimulus is driven; the expected slot vector comes from absolute writeback times.
module tb_writeback_slot_scheduler;
  import writeback_slot_scheduler_pkg::*;

  localparam logic [1:0] P_SX  = 2'd0;
  localparam logic [1:0] P_MEM = 2'd1;
  localparam logic [1:0] P_MX  = 2'd2;

  typedef struct {
    logic [3:0] oh;
    int         pipe;
    logic       perf;
  } exp_t;

  logic          clk;
  logic          reset;
  logic [3:0]    ts_req_valid;
  pipeline_sel_t ts_req_pipeline [NUM_THREADS];
  logic          ss_hold;
  logic          wb_rollback_en;
  thread_idx_t   wb_rollback_thread_idx;
  logic [3:0]    wss_grant_oh;
  logic          wss_grant_valid;
  pipeline_sel_t wss_grant_pipeline;
  logic [5:0]    wss_slot_busy;
  logic          perf_wb_conflict;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb[$];
  int   resv[$];

  writeback_slot_scheduler dut (
    .clk                    (clk),
    .reset                  (reset),
    .ts_req_valid           (ts_req_valid),
    .ts_req_pipeline        (ts_req_pipeline),
    .ss_hold                (ss_hold),
    .wb_rollback_en         (wb_rollback_en),
    .wb_rollback_thread_idx (wb_rollback_thread_idx),
    .wss_grant_oh           (wss_grant_oh),
    .wss_grant_valid        (wss_grant_valid),
    .wss_grant_pipeline     (wss_grant_pipeline),
    .wss_slot_busy          (wss_slot_busy),
    .perf_wb_conflict       (perf_wb_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int lat_of(input int p);
    if (p == 0) return 2;
    if (p == 1) return 3;
    return 6;
  endfunction

  function automatic int pipe_of(input logic [7:0] p, input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return int'(p[2*i +: 2]);
    return 0;
  endfunction

  // Called just after a rising edge; compares at the falling edge, returns after the next rise.
  task automatic cycle(input logic [3:0] v, input logic [7:0] p, input logic hold,
                       input logic rb_en, input logic [1:0] rb_idx,
                       input logic [3:0] e_oh, input logic e_perf);
    exp_t       e;
    exp_t       got;
    logic [5:0] es;
    ts_req_valid = v;
    for (int i = 0; i < 4; i++) ts_req_pipeline[i] = pipeline_sel_t'(p[2*i +: 2]);
    ss_hold = hold;
    wb_rollback_en = rb_en;
    wb_rollback_thread_idx = rb_idx;
    e.oh = e_oh;
    e.pipe = pipe_of(p, e_oh);
    e.perf = e_perf;
    sb.push_back(e);
    #4;
    got = sb.pop_front();
    es = '0;
    foreach (resv[k])
      for (int j = 0; j < 6; j++) if (resv[k] == cyc + j + 1) es[j] = 1'b1;
    chk("grant_oh", 32'(wss_grant_oh), 32'(got.oh));
    chk("grant_valid", 32'(wss_grant_valid), 32'(got.oh != 4'd0));
    if (got.oh != 4'd0) chk("grant_pipeline", 32'(wss_grant_pipeline), 32'(got.pipe));
    chk("perf_wb_conflict", 32'(perf_wb_conflict), 32'(got.perf));
    chk("slot_busy", 32'(wss_slot_busy), 32'(es));
    if (got.oh != 4'd0) resv.push_back(cyc + lat_of(got.pipe));
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(4'b0000, 8'h00, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    ts_req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) ts_req_pipeline[i] = PIPE_SCYCLE_ARITH;
    ss_hold = 1'b0;
    wb_rollback_en = 1'b0;
    wb_rollback_thread_idx = '0;
    #3;
    chk("reset_grant", 32'(wss_grant_oh), 32'd0);
    chk("reset_slot", 32'(wss_slot_busy), 32'd0);
    chk("reset_perf", 32'(perf_wb_conflict), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // T0 to the multi-cycle pipe, then T1 to the single-cycle pipe.
    cycle(4'b0001, {P_SX, P_SX, P_SX, P_MX}, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b0);
    idle(1);
    cycle(4'b0010, {P_SX, P_SX, P_SX, P_SX}, 1'b0, 1'b0, 2'd0, 4'b0010, 1'b0);
    idle(4);

    // Memory grant blocks a single-cycle request that would land on the same cycle.
    cycle(4'b0100, {P_SX, P_MEM, P_SX, P_SX}, 1'b0, 1'b0, 2'd0, 4'b0100, 1'b0);
    cycle(4'b1000, {P_SX, P_MEM, P_SX, P_SX}, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    cycle(4'b1000, {P_SX, P_MEM, P_SX, P_SX}, 1'b0, 1'b0, 2'd0, 4'b1000, 1'b1);
    idle(2);

    // Everyone requests single-cycle every cycle: strict rotation.
    cycle(4'b1111, 8'h00, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b0);
    cycle(4'b1111, 8'h00, 1'b0, 1'b0, 2'd0, 4'b0010, 1'b0);
    cycle(4'b1111, 8'h00, 1'b0, 1'b0, 2'd0, 4'b0100, 1'b0);
    cycle(4'b1111, 8'h00, 1'b0, 1'b0, 2'd0, 4'b1000, 1'b0);
    cycle(4'b1111, 8'h00, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b0);
    idle(2);

    // Rollback of the only requester, then of one of two requesters.
    cycle(4'b0100, 8'h00, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b0);
    cycle(4'b0100, 8'h00, 1'b0, 1'b0, 2'd0, 4'b0100, 1'b0);
    cycle(4'b0101, 8'h00, 1'b0, 1'b1, 2'd2, 4'b0001, 1'b0);
    idle(1);

    // Multi-cycle grant, then a 3-cycle hold with requests pending.
    cycle(4'b0010, {P_SX, P_SX, P_MX, P_SX}, 1'b0, 1'b0, 2'd0, 4'b0010, 1'b0);
    for (int i = 0; i < 3; i++) cycle(4'b1111, 8'h00, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0);
    idle(3);
    chk("hold_slot_drained", 32'(wss_slot_busy), 32'd0);
    cycle(4'b1111, 8'h00, 1'b0, 1'b0, 2'd0, 4'b0100, 1'b0);
    idle(2);

    // Build 6'b010101, then reset mid-operation.
    cycle(4'b1000, {P_MX, P_SX, P_SX, P_SX}, 1'b0, 1'b0, 2'd0, 4'b1000, 1'b0);
    cycle(4'b0001, {P_SX, P_SX, P_SX, P_MEM}, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b0);
    cycle(4'b0010, {P_SX, P_SX, P_MX, P_SX}, 1'b0, 1'b0, 2'd0, 4'b0010, 1'b0);
    chk("pre_reset_slot", 32'(wss_slot_busy), 32'h15);
    idle(1);
    ts_req_valid = 4'b1111;
    reset = 1'b1;
    #1;
    chk("async_reset_slot", 32'(wss_slot_busy), 32'd0);
    chk("async_reset_grant", 32'(wss_grant_oh), 32'd0);
    chk("async_reset_valid", 32'(wss_grant_valid), 32'd0);
    chk("async_reset_perf", 32'(perf_wb_conflict), 32'd0);
    resv.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(4'b1111, 8'h00, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b0);
    cycle(4'b1111, 8'h00, 1'b0, 1'b0, 2'd0, 4'b0010, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
